// File: rtl/mantissa_shift_sequencer_pkg.sv
// Shared definitions for the mantissa shift sequencer: state encoding,
// shift-register mode codes and the alignment saturation helpers.
// Optional build macro used by the top module: SHIFT_SEQ_ABORT_EN.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT_R = 3'd2,
    ST_SHIFT_L = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Mode codes understood by the PIPO bidirectional shift register.
  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_RIGHT = 2'b01;
  localparam logic [1:0] SR_LEFT  = 2'b10;
  localparam logic [1:0] SR_LOAD  = 2'b11;

  localparam int unsigned MANT_W = 24;

  // Beyond width+2 right shifts every mantissa bit already sits in
  // guard, round or sticky, so further shifting changes nothing.
  function automatic int unsigned align_max(input int unsigned width);
    return width + 2;
  endfunction

  localparam int unsigned ALIGN_MAX = align_max(MANT_W);

  function automatic int unsigned sat_amount(input int unsigned amt,
                                             input int unsigned cap);
    return (amt > cap) ? cap : amt;
  endfunction

endpackage

// File: rtl/mantissa_shift_sequencer_step_counter.sv
// Loadable down-counter with a terminal-count flag. The sequencer loads it
// with the effective alignment amount and decrements it once per right
// shift; tc marks the last shift.
module shift_step_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == CW'(1));

endmodule

// File: rtl/mantissa_shift_sequencer.sv
// Control FSM for the 24-bit PIPO bidirectional mantissa shift register of
// the floating-point adder. Loads a mantissa, then right-shifts it by the
// (saturated) exponent difference for alignment, or left-shifts it until the
// hidden-bit position is set for normalization, reporting the shift count.
// Optional build macro: SHIFT_SEQ_ABORT_EN adds the abort input and the
// aborted status output.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; S=hold, busy low
// ST_LOAD    | S=load for one cycle; register holds the mantissa next cycle
// ST_SHIFT_R | alignment: S=right while the step counter runs down
// ST_SHIFT_L | normalization: S=left until msb set, zero, or count limit
// ST_DONE    | one-cycle done pulse, then back to idle
module mantissa_shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int SHAMT_W = 8,
  parameter int CNT_W   = 5
) (
  input  logic               Clk,
  input  logic               Clear,
  input  logic               start,
  input  logic               mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               msb_in,
  input  logic               zero_in,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic [1:0]         S,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   lcount,
  output logic               zero_flag
);

  localparam int unsigned AMAX   = align_max(WIDTH);
  localparam int          STEP_W = $clog2(AMAX + 1);

  state_e             state_d, state_q;
  logic               mode_d, mode_q;
  logic [CNT_W-1:0]   lcount_d, lcount_q;
  logic               zero_flag_d, zero_flag_q;
  logic [1:0]         s_code;
  logic               step_load;
  logic               step_en;
  logic [STEP_W-1:0]  step_count;
  logic               step_tc;
  logic [STEP_W-1:0]  amt_eff;
  logic               abort_req;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Saturate the requested exponent difference before it reaches the counter.
  assign amt_eff = STEP_W'(sat_amount(32'(shamt), AMAX));

  shift_step_counter #(
    .CW (STEP_W)
  ) u_step_counter (
    .clk      (Clk),
    .rst      (Clear),
    .load     (step_load),
    .load_val (amt_eff),
    .en       (step_en),
    .count    (step_count),
    .tc       (step_tc)
  );

  // Next-state, mode code and status updates; SHIFT_L decides from the
  // register contents seen this cycle.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lcount_d    = lcount_q;
    zero_flag_d = zero_flag_q;
    s_code      = SR_HOLD;
    step_load   = 1'b0;
    step_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode;
          lcount_d    = '0;
          zero_flag_d = 1'b0;
          step_load   = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_code = SR_LOAD;
        if (mode_q) begin
          state_d = ST_SHIFT_L;
        end else if (step_count == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT_R;
        end
      end
      ST_SHIFT_R: begin
        if (abort_req) begin
          state_d = ST_DONE;
        end else begin
          s_code  = SR_RIGHT;
          step_en = 1'b1;
          if (step_tc) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT_L: begin
        if (abort_req) begin
          state_d = ST_DONE;
        end else if (zero_in) begin
          zero_flag_d = 1'b1;
          state_d     = ST_DONE;
        end else if (msb_in || (lcount_q == CNT_W'(WIDTH - 1))) begin
          state_d = ST_DONE;
        end else begin
          s_code   = SR_LEFT;
          lcount_d = lcount_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and status registers; Clear drops any transfer in flight.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      lcount_q    <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      lcount_q    <= lcount_d;
      zero_flag_q <= zero_flag_d;
    end
  end

`ifdef SHIFT_SEQ_ABORT_EN
  logic aborted_d, aborted_q;

  // Aborted status: cleared by a new start, set on the abort that ends a shift.
  always_comb begin
    aborted_d = aborted_q;
    if ((state_q == ST_IDLE) && start) begin
      aborted_d = 1'b0;
    end else if (((state_q == ST_SHIFT_R) || (state_q == ST_SHIFT_L)) && abort) begin
      aborted_d = 1'b1;
    end
  end

  // Aborted status register.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign aborted = aborted_q;
`endif

  // Clear forces the register into hold and the handshake low immediately.
  assign S         = Clear ? SR_HOLD : s_code;
  assign busy      = ~Clear & (state_q != ST_IDLE);
  assign done      = ~Clear & (state_q == ST_DONE);
  assign lcount    = lcount_q;
  assign zero_flag = zero_flag_q;

endmodule
